mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 118 +++++++++++
 tb/tb_mem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Fixed-latency word memory answering CPU read/write requests.
// Revision : 1.0
// ============================================================================
module mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        MemReady,
    output logic        MemErr,
    output logic        busy
);

    localparam int        DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_cnt_load = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [3:0]              r_cnt, w_cnt_nxt;
    logic                    r_err;
    logic                    r_is_write;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [31:0]             r_wdata;
    logic [31:0]             r_rdata;
    logic [31:0]             r_mem [0:DEPTH-1];

    logic                    w_accept;
    logic                    w_access;
    logic                    w_req_err;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        w_req_err   = (MemRead && MemWrite) ||
                      (address[1:0] != 2'b00) ||
                      ((address >> (ADDR_WIDTH + 2)) != 32'd0);
        case (r_state)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT;
                    // Rejected requests spend a single cycle in WAIT so the
                    // error pulse lands one edge after acceptance.
                    w_cnt_nxt   = w_req_err ? 4'd0 : c_cnt_load;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                    w_access    = !r_err;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_err      <= 1'b0;
            r_is_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_err      <= w_req_err;
                r_is_write <= MemWrite;
                r_idx      <= address[ADDR_WIDTH+1:2];
                r_wdata    <= wdata;
            end
            if (w_access && !r_is_write) begin
                r_rdata <= r_mem[r_idx];
            end
        end
    end

    // Storage is never reset; a reset edge still blocks a pending write.
    always_ff @(posedge clk) begin
        if (rst_n && w_access && r_is_write) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign rdata    = r_rdata;
    assign MemReady = (r_state == S_RESP);
    assign MemErr   = (r_state == S_RESP) && r_err;
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Directed self-checking bench for mem_responder (LATENCY 3 and 1).
// Revision : 1.0
// ============================================================================
module tb_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        MemRead, MemWrite;
    logic [31:0] address, wdata;
    logic [31:0] rdata;
    logic        MemReady, MemErr, busy;

    logic        rd1, wr1;
    logic [31:0] addr1, wdata1;
    logic [31:0] rdata1;
    logic        ready1, err1, busy1;

    int n_assert;
    int n_fail;
    int n;

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .address  (address),
        .wdata    (wdata),
        .rdata    (rdata),
        .MemReady (MemReady),
        .MemErr   (MemErr),
        .busy     (busy)
    );

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut_l1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .MemRead  (rd1),
        .MemWrite (wr1),
        .address  (addr1),
        .wdata    (wdata1),
        .rdata    (rdata1),
        .MemReady (ready1),
        .MemErr   (err1),
        .busy     (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one accepting edge, then drop it.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        MemRead  = rd;
        MemWrite = wr;
        address  = a;
        wdata    = d;
        tick();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    // Edges from the accepting edge until MemReady is seen, bounded.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (MemReady !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; address = 32'h2; wdata = 32'h0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;

        // Reset held with a request pending
        tick(); tick();
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ready", {31'b0, MemReady}, 32'h0);
        chk("rst_err",   {31'b0, MemErr},   32'h0);
        chk("rst_busy",  {31'b0, busy},     32'h0);
        rst_n = 1'b1;
        tick();
        MemRead = 1'b0;
        chk("rel_accept_busy", {31'b0, busy}, 32'h1);
        chk("rel_no_early_ready", {31'b0, MemReady}, 32'h0);
        tick();
        chk("rel_err_ready", {30'b0, MemReady, MemErr}, 32'h3);
        chk("rel_err_rdata", rdata, 32'h0);
        tick();
        chk("rel_idle", {30'b0, busy, MemReady}, 32'h0);

        // Write then read
        issue(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        wait_ready(n);
        chk("wr_latency", n, 3);
        chk("wr_err", {31'b0, MemErr}, 32'h0);
        tick();
        chk("wr_done_idle", {30'b0, busy, MemReady}, 32'h0);
        issue(1'b1, 1'b0, 32'h10, 32'h0);
        wait_ready(n);
        chk("rd_latency", n, 3);
        chk("rd_data", rdata, 32'hDEAD_BEEF);
        tick();
        chk("rd_held", rdata, 32'hDEAD_BEEF);
        chk("rd_pulse_one", {31'b0, MemReady}, 32'h0);

        // Error cases
        issue(1'b1, 1'b0, 32'h12, 32'h0);
        wait_ready(n);
        chk("mis_latency", n, 1);
        chk("mis_err", {31'b0, MemErr}, 32'h1);
        chk("mis_rdata", rdata, 32'hDEAD_BEEF);
        tick();
        issue(1'b1, 1'b1, 32'h10, 32'h5555_AAAA);
        wait_ready(n);
        chk("both_latency", n, 1);
        chk("both_err", {31'b0, MemErr}, 32'h1);
        tick();
        issue(1'b1, 1'b0, 32'h1000, 32'h0);
        wait_ready(n);
        chk("oor_latency", n, 1);
        chk("oor_err", {31'b0, MemErr}, 32'h1);
        tick();
        issue(1'b1, 1'b0, 32'h10, 32'h0);
        wait_ready(n);
        chk("both_no_update", rdata, 32'hDEAD_BEEF);
        tick();
        issue(1'b0, 1'b1, 32'hFFC, 32'hA5A5_5A5A);
        wait_ready(n);
        chk("top_wr_err", {31'b0, MemErr}, 32'h0);
        tick();
        issue(1'b1, 1'b0, 32'hFFC, 32'h0);
        wait_ready(n);
        chk("top_rd", rdata, 32'hA5A5_5A5A);
        tick();

        // Reset mid-write
        issue(1'b0, 1'b1, 32'h20, 32'h1111_1111);
        wait_ready(n);
        tick();
        issue(1'b0, 1'b1, 32'h20, 32'h0123_4567);
        tick();
        rst_n = 1'b0;
        tick();
        chk("abort_busy", {30'b0, busy, MemReady}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("abort_no_ready", {31'b0, MemReady}, 32'h0);
        issue(1'b1, 1'b0, 32'h20, 32'h0);
        wait_ready(n);
        chk("abort_rd_latency", n, 3);
        chk("abort_rd_data", rdata, 32'h1111_1111);
        tick();

        // Inputs changed while in flight are ignored
        issue(1'b0, 1'b1, 32'h34, 32'h3434_3434);
        wait_ready(n);
        tick();
        issue(1'b0, 1'b1, 32'h30, 32'hCAFE_F00D);
        address = 32'h34;
        wdata   = 32'h0BAD_F00D;
        wait_ready(n);
        tick();
        issue(1'b1, 1'b0, 32'h30, 32'h0);
        wait_ready(n);
        chk("stab_captured", rdata, 32'hCAFE_F00D);
        tick();
        issue(1'b1, 1'b0, 32'h34, 32'h0);
        wait_ready(n);
        chk("stab_other", rdata, 32'h3434_3434);
        tick();

        // Held read request is re-accepted after the response
        MemRead = 1'b1; address = 32'hFFC;
        tick();
        wait_ready(n);
        chk("held_first", n, 3);
        tick();
        chk("held_idle", {30'b0, busy, MemReady}, 32'h0);
        tick();
        MemRead = 1'b0;
        chk("held_reaccept", {31'b0, busy}, 32'h1);
        wait_ready(n);
        chk("held_second", n, 3);
        chk("held_data", rdata, 32'hA5A5_5A5A);
        tick();

        // LATENCY=1 instance
        wr1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h4040_4040;
        tick();
        wr1 = 1'b0;
        tick();
        chk("l1_wr_ready", {30'b0, ready1, err1}, 32'h2);
        tick();
        rd1 = 1'b1;
        tick();
        tick();
        chk("l1_rd_ready", {31'b0, ready1}, 32'h1);
        chk("l1_rd_data", rdata1, 32'h4040_4040);
        tick();
        chk("l1_idle", {30'b0, busy1, ready1}, 32'h0);
        tick();
        rd1 = 1'b0;
        chk("l1_reaccept", {30'b0, busy1, ready1}, 32'h2);
        tick();
        chk("l1_second_ready", {31'b0, ready1}, 32'h1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
